// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: forwarding,
// load-use/interlock stalls, data-memory wait with timeout, flush arbitration, counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemErr,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  mem_state_t     state_reg, state_next;
  logic [WCW-1:0] wcnt_reg, wcnt_next;
  logic           mem_err_reg;
  logic           mstall;
  logic           timeout;
  logic           luse;
  logic           branch_flush;
  fwd_sel_t       fwd_a, fwd_b;

  // Forwarding paths and RAW detection differ structurally between the two modes.
  generate
    if (FWD_EN != 0) begin : g_fwd
      logic load_e;

      always_comb begin
        fwd_a = FWD_RF;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
          fwd_a = FWD_M;
        end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
          fwd_a = FWD_W;
        end
      end

      always_comb begin
        fwd_b = FWD_RF;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
          fwd_b = FWD_M;
        end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
          fwd_b = FWD_W;
        end
      end

      assign load_e = (ResultSrcE == RES_LOAD) && RegWriteE && (RdE != '0);
      assign luse   = load_e && ((RdE == Rs1D) || (RdE == Rs2D));
    end else begin : g_interlock
      logic hit1, hit2;

      // No RF-to-W check: the register file writes before it reads in the same cycle.
      assign hit1 = (Rs1D != '0) &&
                    ((RegWriteE && (Rs1D == RdE)) || (RegWriteM && (Rs1D == RdM)));
      assign hit2 = (Rs2D != '0) &&
                    ((RegWriteE && (Rs2D == RdE)) || (RegWriteM && (Rs2D == RdM)));
      assign luse  = hit1 || hit2;
      assign fwd_a = FWD_RF;
      assign fwd_b = FWD_RF;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    mstall     = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (MemReqM && !MemReadyM) begin
          mstall     = 1'b1;
          state_next = WAIT;
          wcnt_next  = WCW'(1);
        end
      end
      WAIT: begin
        if (MemReadyM) begin
          state_next = IDLE;
        end else if (wcnt_reg == WCW'(MEM_TIMEOUT)) begin
          // Give up on the access and let the pipeline advance; the error is sticky.
          timeout    = 1'b1;
          state_next = IDLE;
        end else begin
          mstall    = 1'b1;
          wcnt_next = wcnt_reg + WCW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      wcnt_reg    <= '0;
      mem_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      if (timeout) begin
        mem_err_reg <= 1'b1;
      end
    end
  end

  // A memory stall freezes a taken branch in E; its flush fires once E advances.
  always_comb begin
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    StallM       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    FlushW       = 1'b0;
    branch_flush = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD       = 1'b1;
      FlushE       = 1'b1;
      branch_flush = 1'b1;
    end else if (luse) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign ForwardAE = rst ? FWD_RF : fwd_a;
  assign ForwardBE = rst ? FWD_RF : fwd_b;
  assign MemErr    = mem_err_reg;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (StallF),
    .count (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_flush),
    .count (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a forwarding instance (short timeout, 4-bit counters)
// and an interlock instance share the stimulus; a negedge monitor checks queued expectations.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic       rwe, rwm, rww, pcsrc, memreq, memrdy;
  logic [1:0] res_src;

  logic [1:0]  fa_f, fb_f, fa_i, fb_i;
  logic        sf_f, sd_f, se_f, sm_f, fd_f, fe_f, fw_f, err_f;
  logic        sf_i, sd_i, se_i, sm_i, fd_i, fe_i, fw_i, err_i;
  logic [3:0]  scnt_f, fcnt_f;
  logic [31:0] scnt_i, fcnt_i;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .MEM_TIMEOUT(4), .CNT_W(4)) dut_f (
    .clk(clk), .rst(rst),
    .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e), .RdE(rde), .RdM(rdm), .RdW(rdw),
    .RegWriteE(rwe), .RegWriteM(rwm), .RegWriteW(rww), .ResultSrcE(res_src),
    .PCSrcE(pcsrc), .MemReqM(memreq), .MemReadyM(memrdy),
    .ForwardAE(fa_f), .ForwardBE(fb_f),
    .StallF(sf_f), .StallD(sd_f), .StallE(se_f), .StallM(sm_f),
    .FlushD(fd_f), .FlushE(fe_f), .FlushW(fw_f), .MemErr(err_f),
    .StallCnt(scnt_f), .FlushCnt(fcnt_f)
  );

  hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .MEM_TIMEOUT(15), .CNT_W(32)) dut_i (
    .clk(clk), .rst(rst),
    .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e), .RdE(rde), .RdM(rdm), .RdW(rdw),
    .RegWriteE(rwe), .RegWriteM(rwm), .RegWriteW(rww), .ResultSrcE(res_src),
    .PCSrcE(pcsrc), .MemReqM(memreq), .MemReadyM(memrdy),
    .ForwardAE(fa_i), .ForwardBE(fb_i),
    .StallF(sf_i), .StallD(sd_i), .StallE(se_i), .StallM(sm_i),
    .FlushD(fd_i), .FlushE(fe_i), .FlushW(fw_i), .MemErr(err_i),
    .StallCnt(scnt_i), .FlushCnt(fcnt_i)
  );

  typedef struct {
    string      nm;
    bit         which;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] st;
    logic [2:0] fl;
    logic       err;
    bit         cnt;
    int         sc;
    int         fc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Monitor: every expectation queued during a cycle is compared at that cycle's negedge.
  exp_t        mon_e;
  logic [12:0] got, want;
  int          got_sc, got_fc;
  bit          bad;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.which) begin
        got    = {fa_i, fb_i, sf_i, sd_i, se_i, sm_i, fd_i, fe_i, fw_i, err_i};
        got_sc = int'(scnt_i);
        got_fc = int'(fcnt_i);
      end else begin
        got    = {fa_f, fb_f, sf_f, sd_f, se_f, sm_f, fd_f, fe_f, fw_f, err_f};
        got_sc = int'(scnt_f);
        got_fc = int'(fcnt_f);
      end
      want = {mon_e.fa, mon_e.fb, mon_e.st, mon_e.fl, mon_e.err};
      bad  = (got !== want) || (mon_e.cnt && ((got_sc != mon_e.sc) || (got_fc != mon_e.fc)));
      n_vec++;
      if (bad) begin
        n_bad++;
        $display("FAIL %s: got fa=%b fb=%b st=%b fl=%b err=%b sc=%0d fc=%0d, want fa=%b fb=%b st=%b fl=%b err=%b%s",
                 mon_e.nm, got[12:11], got[10:9], got[8:5], got[4:2], got[0], got_sc, got_fc,
                 mon_e.fa, mon_e.fb, mon_e.st, mon_e.fl, mon_e.err,
                 mon_e.cnt ? $sformatf(" sc=%0d fc=%0d", mon_e.sc, mon_e.fc) : "");
      end else begin
        $display("ok   %s: fa=%b fb=%b st=%b fl=%b err=%b sc=%0d fc=%0d",
                 mon_e.nm, got[12:11], got[10:9], got[8:5], got[4:2], got[0], got_sc, got_fc);
      end
    end
  end

  task automatic clr();
    rs1d = '0; rs2d = '0; rs1e = '0; rs2e = '0; rde = '0; rdm = '0; rdw = '0;
    rwe = 1'b0; rwm = 1'b0; rww = 1'b0; res_src = 2'b00;
    pcsrc = 1'b0; memreq = 1'b0; memrdy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expectation for the inputs currently driven, then advance one cycle.
  task automatic chk(input string nm, input bit which, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [3:0] st, input logic [2:0] fl, input logic err,
                     input int sc = -1, input int fc = -1);
    exp_t e;
    e.nm = nm; e.which = which; e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.err = err;
    e.cnt = (sc >= 0); e.sc = sc; e.fc = fc;
    sb.push_back(e);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    tick();
    rst = 1'b0;
  endtask

  localparam logic [3:0] ST_NO = 4'b0000, ST_ALL = 4'b1111, ST_LU = 4'b1100;
  localparam logic [2:0] FL_NO = 3'b000, FL_MEM = 3'b001, FL_LU = 3'b010, FL_BR = 3'b110;

  initial begin
    rst = 1'b1;
    clr();
    tick();
    tick();
    // Matching forward conditions must be masked while in reset.
    rwm = 1'b1; rdm = 5'd5; rs1e = 5'd5;
    chk("reset_outputs", 0, 2'b00, 2'b00, ST_NO, 3'b111, 1'b0, 0, 0);
    rst = 1'b0;

    clr(); rwm = 1'b1; rdm = 5'd5; rww = 1'b1; rdw = 5'd5; rs1e = 5'd5;
    chk("fwd_m_beats_w", 0, 2'b10, 2'b00, ST_NO, FL_NO, 1'b0);
    rwm = 1'b0; rs2e = 5'd5;
    chk("fwd_w_both", 0, 2'b01, 2'b01, ST_NO, FL_NO, 1'b0);
    clr(); rwm = 1'b1; rdm = 5'd0; rww = 1'b1; rdw = 5'd0;
    chk("fwd_x0_never", 0, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0);
    clr(); rwm = 1'b1; rdm = 5'd9; rs2e = 5'd9; rww = 1'b1; rdw = 5'd3; rs1e = 5'd3;
    chk("fwd_a_w_b_m", 0, 2'b01, 2'b10, ST_NO, FL_NO, 1'b0);
    clr(); rdm = 5'd9; rdw = 5'd9; rs1e = 5'd9; rs2e = 5'd9;
    chk("fwd_no_regwrite", 0, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0);

    clr(); res_src = RES_LOAD; rwe = 1'b1; rde = 5'd6; rs2d = 5'd6;
    chk("load_use", 0, 2'b00, 2'b00, ST_LU, FL_LU, 1'b0);
    clr();
    chk("load_use_count", 0, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0, 1, 0);
    clr(); rwe = 1'b1; rde = 5'd6; rs1d = 5'd6;
    chk("alu_no_luse", 0, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0);
    clr(); res_src = RES_LOAD; rwe = 1'b1; rde = 5'd0;
    chk("load_x0_no_luse", 0, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0);
    clr(); res_src = RES_LOAD; rwe = 1'b1; rde = 5'd6; rs1d = 5'd6; pcsrc = 1'b1;
    chk("branch_over_luse", 0, 2'b00, 2'b00, ST_NO, FL_BR, 1'b0);
    clr();
    chk("branch_count", 0, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0, 1, 1);

    do_reset();
    memreq = 1'b1;
    for (int i = 0; i < 3; i++) chk($sformatf("mem_wait_%0d", i), 0, 2'b00, 2'b00, ST_ALL, FL_MEM, 1'b0);
    memrdy = 1'b1;
    chk("mem_ready", 0, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0);
    clr();
    chk("mem_idle_count", 0, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0, 3, 0);

    do_reset();
    memreq = 1'b1; pcsrc = 1'b1;
    for (int i = 0; i < 3; i++) chk($sformatf("br_held_%0d", i), 0, 2'b00, 2'b00, ST_ALL, FL_MEM, 1'b0);
    memrdy = 1'b1;
    chk("br_released", 0, 2'b00, 2'b00, ST_NO, FL_BR, 1'b0);
    clr();
    chk("br_held_count", 0, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0, 3, 1);

    do_reset();
    memreq = 1'b1;
    for (int i = 0; i < 4; i++) chk($sformatf("to_wait_%0d", i), 0, 2'b00, 2'b00, ST_ALL, FL_MEM, 1'b0);
    chk("to_release", 0, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0);
    clr();
    chk("memerr_set", 0, 2'b00, 2'b00, ST_NO, FL_NO, 1'b1, 4, 0);
    memreq = 1'b1; memrdy = 1'b1;
    chk("memerr_sticky", 0, 2'b00, 2'b00, ST_NO, FL_NO, 1'b1);
    memrdy = 1'b0;
    chk("rw_enter_wait", 0, 2'b00, 2'b00, ST_ALL, FL_MEM, 1'b1);
    chk("rw_in_wait", 0, 2'b00, 2'b00, ST_ALL, FL_MEM, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr();
    // State WAIT would stall here because MemReadyM is low.
    chk("rst_mid_wait", 0, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0, 0, 0);

    do_reset();
    res_src = RES_LOAD; rwe = 1'b1; rde = 5'd6; rs1d = 5'd6;
    repeat (17) tick();
    pcsrc = 1'b1;
    repeat (17) tick();
    clr();
    chk("counters_saturate", 0, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0, 15, 15);

    do_reset();
    rwm = 1'b1; rdm = 5'd7; rs1d = 5'd7; rs1e = 5'd7;
    chk("il_rdm", 1, 2'b00, 2'b00, ST_LU, FL_LU, 1'b0);
    clr(); rwe = 1'b1; rde = 5'd8; rs2d = 5'd8;
    chk("il_rde_alu", 1, 2'b00, 2'b00, ST_LU, FL_LU, 1'b0);
    clr(); rww = 1'b1; rdw = 5'd7; rs1d = 5'd7;
    chk("il_w_no_check", 1, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0);
    clr(); rwm = 1'b1; rdm = 5'd0;
    chk("il_x0", 1, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0);
    clr(); rdm = 5'd7; rs1d = 5'd7;
    chk("il_no_regwrite", 1, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0);
    clr();
    chk("il_count", 1, 2'b00, 2'b00, ST_NO, FL_NO, 1'b0, 2, 0);

    @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the 5-stage RV32I pipeline. It replaces the purely combinational hazard unit. It adds multi-cycle data-memory wait handling with a timeout, a selectable no-forwarding interlock mode, branch-flush arbitration against stalls, and saturating performance counters. It sits beside the stage modules in the pipeline top and drives every stage's stall/flush inputs and the Execute forwarding muxes.

Parameters:
REG_AW, 5, register address width
FWD_EN, 1, 1 = forwarding from M/W; 0 = interlock on every RAW against E and M
MEM_TIMEOUT, 15, max WAIT cycles before forced release (≥1)
CNT_W, 32, performance counter width

Ports:
clk  in  1  CPU clock
rst  in  1  synchronous, active-high reset
Rs1D, Rs2D  in  REG_AW  Decode source registers
Rs1E, Rs2E, RdE  in  REG_AW  Execute source/destination registers
RdM, RdW  in  REG_AW  Memory/Writeback destinations
RegWriteE, RegWriteM, RegWriteW  in  1  stage write enables
ResultSrcE  in  2  Execute result select; RES_LOAD (2'b01) = load
PCSrcE  in  1  taken branch/jump in Execute
MemReqM  in  1  load/store in Memory stage
MemReadyM  in  1  data memory ready/ack
ForwardAE, ForwardBE  out  2  00 = RF, 10 = ALUResultM, 01 = ResultW
StallF, StallD, StallE, StallM  out  1  hold stage register
FlushD, FlushE, FlushW  out  1  insert bubble
MemErr  out  1  sticky timeout flag
StallCnt, FlushCnt  out  CNT_W  performance counters

Behaviour:
- Reset (sync, rst=1): FSM→IDLE, wait counter=0, MemErr=0, StallCnt=FlushCnt=0. While rst=1, all Stall*=0, FlushD=FlushE=FlushW=1, Forward*=00.
- Forwarding (FWD_EN=1), combinational, per source A/B:
  - 10 if RegWriteM && RdM!=0 && RdM==Rs*E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs*E;
  - else 00.
  - M beats W. x0 is never forwarded.
  - With FWD_EN=0, Forward* are tied to 00.
- Load-use (FWD_EN=1): luse = ResultSrcE==RES_LOAD && RegWriteE && RdE!=0 && RdE∈{Rs1D,Rs2D}.
- Interlock (FWD_EN=0): luse = any nonzero Rs*D matching RdE (RegWriteE) or RdM (RegWriteM). W needs no check because the RF is write-first.
- Memory FSM:
  - IDLE: MemReqM && !MemReadyM → mstall=1 this cycle; next state WAIT, wcnt=1.
  - WAIT: mstall=!MemReadyM. MemReadyM=1 → IDLE, no stall that cycle. wcnt==MEM_TIMEOUT with !MemReadyM → MemErr←1, mstall=0 that cycle, → IDLE. Otherwise wcnt++.
  - MemErr clears only on rst.
- Priority (highest first):
  1. mstall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. Any branch in E is held, and its flush is taken when E advances, because PCSrcE stays high.
  2. PCSrcE: FlushD=FlushE=1, no stalls. This overrides luse, since the stalled D instruction is wrong-path.
  3. luse: StallF=StallD=1, FlushE=1.
  4. Otherwise all 0.
- Counters:
  - StallCnt +1 on each cycle StallF=1.
  - FlushCnt +1 on each cycle with priority-2 active.
  - Both saturate at 2^CNT_W−1 and never wrap.
- Latency: all stall/flush/forward outputs are combinational from the current inputs and state. Counters and MemErr update at the next clk edge.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10};
  - RES_LOAD constant;
  - mem_state_t enum {IDLE, WAIT}.
- One sub-module, sat_counter (param W; ports clk, rst, inc, count), is instantiated twice.

Test Plan:
- add x5 in M, Rs1E=5, RegWriteM=1 → ForwardAE=10. Same with RdW=5 only → 01. Rs1E=0 → 00.
- Load in E (RdE=6), Rs2D=6 → StallF=StallD=FlushE=1 for one cycle, StallCnt +1. Same with PCSrcE=1 → FlushD=FlushE=1, StallF=0, FlushCnt +1.
- MemReqM=1, MemReadyM low 3 cycles then high → StallF..StallM=1 and FlushW=1 for exactly 3 cycles, FSM returns to IDLE, StallCnt=3.
- MemReadyM held low, MEM_TIMEOUT=4 → stall for 4 cycles, then MemErr=1 and stalls drop. MemErr stays 1 until rst.
- PCSrcE=1 during mstall → FlushD=FlushE=0 while stalled, then 1 on the first unstalled cycle.
- FWD_EN=0, RegWriteM=1, RdM=7, Rs1D=7 → StallF=StallD=FlushE=1, Forward*=00. rst asserted mid-WAIT → IDLE next cycle, counters 0.
